wishbone_bus_if: RTL and testbench

- Bridges the CPU core's memory-side port (ram_* or rom_* signals) to a single-master Wishbone classic bus.
- One instance sits downstream of the core's data port and a second downstream of its instruction port.
- Converts the core's single-cycle access request into a multi-cycle Wishbone transaction.
- Raises a stall request so the pipeline holds until the slave acknowledges. Buffers read data if the pipeline is still stalled by another source when the ack arrives.

---
 rtl/wishbone_bus_if_if.sv | 24 ++
 rtl/wishbone_bus_if.sv | 111 +++++++++++
 tb/tb_wishbone_bus_if.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/wishbone_bus_if_if.sv
// rtl/wishbone_bus_if_if.sv - Wishbone classic single-master bus signal bundle
interface wishbone_bus_if_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [DATA_W-1:0]   wb_data_i;
    logic                wb_ack_i;
    logic [ADDR_W-1:0]   wb_addr_o;
    logic [DATA_W-1:0]   wb_data_o;
    logic                wb_we_o;
    logic [DATA_W/8-1:0] wb_sel_o;
    logic                wb_stb_o;
    logic                wb_cyc_o;

    modport master (
        input  wb_data_i, wb_ack_i,
        output wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
    );

    modport slave (
        output wb_data_i, wb_ack_i,
        input  wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
    );
endinterface

// File: rtl/wishbone_bus_if.sv
// rtl/wishbone_bus_if.sv - core memory port to Wishbone classic bridge with stall request
module wishbone_bus_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                cpu_ce_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]   cpu_data_i,
    input  logic                cpu_we_i,
    input  logic [3:0]          cpu_sel_i,
    output logic [DATA_W-1:0]   cpu_data_o,
    output logic                stallreq,
    output logic                err_o,
    wishbone_bus_if_if.master   wb
);
    localparam logic [1:0] IDLE           = 2'd0;
    localparam logic [1:0] BUSY           = 2'd1;
    localparam logic [1:0] WAIT_FOR_STALL = 2'd2;

    localparam int TMAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [1:0]        state;
    logic [DATA_W-1:0] rd_buf;
    logic [31:0]       cnt;
    logic              timeout_hit;

    // Flush and a same-cycle ack both outrank the timeout abort.
    assign timeout_hit = (TIMEOUT > 0) && (state == BUSY) && !wb.wb_ack_i &&
                         !flush_i && (cnt == 32'(TMAX));

    always_comb begin
        stallreq   = 1'b0;
        cpu_data_o = '0;
        case (state)
            IDLE: stallreq = cpu_ce_i && !flush_i;
            BUSY: begin
                if (!flush_i) begin
                    if (wb.wb_ack_i) begin
                        if (!wb.wb_we_o) cpu_data_o = wb.wb_data_i;
                    end else begin
                        stallreq = !timeout_hit;
                    end
                end
            end
            WAIT_FOR_STALL: cpu_data_o = rd_buf;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wb.wb_addr_o <= '0;
            wb.wb_data_o <= '0;
            wb.wb_we_o   <= 1'b0;
            wb.wb_sel_o  <= '0;
            wb.wb_stb_o  <= 1'b0;
            wb.wb_cyc_o  <= 1'b0;
            rd_buf       <= '0;
            cnt          <= '0;
            err_o        <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        wb.wb_cyc_o  <= 1'b1;
                        wb.wb_stb_o  <= 1'b1;
                        wb.wb_addr_o <= cpu_addr_i;
                        wb.wb_data_o <= cpu_data_i;
                        wb.wb_we_o   <= cpu_we_i;
                        wb.wb_sel_o  <= cpu_sel_i;
                        rd_buf       <= '0;
                        cnt          <= '0;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush_i || timeout_hit || wb.wb_ack_i) begin
                        wb.wb_cyc_o  <= 1'b0;
                        wb.wb_stb_o  <= 1'b0;
                        wb.wb_addr_o <= '0;
                        wb.wb_data_o <= '0;
                        wb.wb_we_o   <= 1'b0;
                        wb.wb_sel_o  <= '0;
                        cnt          <= '0;
                        if (flush_i || timeout_hit) begin
                            rd_buf <= '0;
                            err_o  <= timeout_hit;
                            state  <= IDLE;
                        end else begin
                            if (!wb.wb_we_o) rd_buf <= wb.wb_data_i;
                            state <= stall_i ? WAIT_FOR_STALL : IDLE;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                WAIT_FOR_STALL: begin
                    if (!stall_i || flush_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wishbone_bus_if.sv
// tb/tb_wishbone_bus_if.sv - randomized transaction-level check of wishbone_bus_if
module tb_wishbone_bus_if;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst, stall_i, flush_i, cpu_ce_i, cpu_we_i;
    logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
    logic [3:0]  cpu_sel_i;
    logic        stallreq, err_o;

    wishbone_bus_if_if bus ();

    wishbone_bus_if #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
        .stallreq(stallreq), .err_o(err_o), .wb(bus)
    );

    always #5 clk = ~clk;

    int          errors = 0, checks = 0;
    int          cyc_total = 0, err_total = 0;
    logic [31:0] last_ack_data = '0;
    logic        chk_en = 1'b0, err_pend = 1'b0;
    logic [31:0] exp_cpu_data, exp_addr, exp_data;
    logic [3:0]  exp_sel;
    logic        exp_stallreq, exp_err, exp_cyc, exp_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_data_o", cpu_data_o, exp_cpu_data);
            chk("stallreq", 32'(stallreq), 32'(exp_stallreq));
            chk("err_o", 32'(err_o), 32'(exp_err));
            chk("wb_cyc_o", 32'(bus.wb_cyc_o), 32'(exp_cyc));
            chk("wb_stb_o", 32'(bus.wb_stb_o), 32'(exp_cyc));
            chk("wb_we_o", 32'(bus.wb_we_o), 32'(exp_we));
            chk("wb_addr_o", bus.wb_addr_o, exp_addr);
            chk("wb_data_o", bus.wb_data_o, exp_data);
            chk("wb_sel_o", 32'(bus.wb_sel_o), 32'(exp_sel));
            if (bus.wb_cyc_o) cyc_total++;
            if (err_o) err_total++;
            if (bus.wb_ack_i && bus.wb_cyc_o && !flush_i) last_ack_data = cpu_data_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_cycle();
        exp_err  = err_pend;
        err_pend = 1'b0;
    endtask

    task automatic bus_idle();
        exp_cyc = 0; exp_we = 0; exp_addr = '0; exp_data = '0; exp_sel = '0;
    endtask

    task automatic bus_act(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] s);
        exp_cyc = 1; exp_we = w; exp_addr = a; exp_data = d; exp_sel = s;
    endtask

    task automatic idle_cycle();
        begin_cycle();
        bus_idle();
        cpu_ce_i = 1'($urandom);
        flush_i = cpu_ce_i ? 1'b1 : 1'($urandom);
        bus.wb_ack_i = 1'($urandom);
        bus.wb_data_i = $urandom;
        stall_i = 1'($urandom);
        exp_stallreq = 0; exp_cpu_data = '0;
        step();
    endtask

    // One core access seen from the pipeline: request cycle, bus cycles, optional stall tail.
    task automatic do_access(input logic [31:0] a, input logic [31:0] d, input logic w,
                             input logic [3:0] s, input int waits, input logic [31:0] rdat,
                             input int extra, input int flush_at);
        begin_cycle();
        bus_idle();
        cpu_ce_i = 1; cpu_addr_i = a; cpu_data_i = d; cpu_we_i = w; cpu_sel_i = s;
        flush_i = 0; stall_i = 1; bus.wb_ack_i = 0; bus.wb_data_i = $urandom;
        exp_stallreq = 1; exp_cpu_data = '0;
        step();
        for (int j = 0; j < 100; j++) begin
            begin_cycle();
            bus_act(a, d, w, s);
            stall_i = 1;
            if (flush_at == j) begin
                flush_i = 1; bus.wb_ack_i = (j == waits); bus.wb_data_i = rdat;
                exp_stallreq = 0; exp_cpu_data = '0;
                step();
                flush_i = 0; bus.wb_ack_i = 0;
                return;
            end
            if (j == waits) begin
                bus.wb_ack_i = 1; bus.wb_data_i = rdat; stall_i = (extra > 0);
                exp_stallreq = 0; exp_cpu_data = w ? '0 : rdat;
                step();
                for (int k = 0; k < extra; k++) begin
                    begin_cycle();
                    bus_idle();
                    bus.wb_ack_i = 1'($urandom); bus.wb_data_i = $urandom;
                    stall_i = (k < extra - 1);
                    exp_stallreq = 0; exp_cpu_data = w ? '0 : rdat;
                    step();
                end
                bus.wb_ack_i = 0;
                return;
            end
            bus.wb_ack_i = 0; bus.wb_data_i = $urandom;
            if (j == TMO - 1) begin
                exp_stallreq = 0; exp_cpu_data = '0;
                step();
                err_pend = 1;
                return;
            end
            exp_stallreq = 1; exp_cpu_data = '0;
            step();
        end
    endtask

    initial begin
        int base_c, base_e, waits, extra, fat;
        rst = 1; stall_i = 0; flush_i = 0; cpu_ce_i = 0; cpu_we_i = 0;
        cpu_addr_i = '0; cpu_data_i = '0; cpu_sel_i = '0;
        bus.wb_ack_i = 0; bus.wb_data_i = '0;
        bus_idle(); exp_stallreq = 0; exp_cpu_data = '0; exp_err = 0;
        step();
        chk_en = 1;
        step();
        chk("reset_cyc", 32'(bus.wb_cyc_o), 32'd0);
        rst = 0;
        idle_cycle();

        base_c = cyc_total;
        do_access(32'h0000_0040, 32'h0, 1'b0, 4'hF, 2, 32'hDEADBEEF, 0, -1);
        chk("read_cyc_len", 32'(cyc_total - base_c), 32'd3);
        chk("read_ack_data", last_ack_data, 32'hDEADBEEF);

        base_c = cyc_total;
        do_access(32'h0000_0080, 32'h1234_5678, 1'b1, 4'h3, 0, 32'hCAFEF00D, 0, -1);
        chk("write_cyc_len", 32'(cyc_total - base_c), 32'd1);
        chk("write_ack_data", last_ack_data, 32'd0);

        do_access(32'h0000_0100, 32'h0, 1'b0, 4'hF, 1, 32'hA5A5A5A5, 3, -1);
        chk("stall_read_data", last_ack_data, 32'hA5A5A5A5);

        base_c = cyc_total;
        do_access(32'h0000_0200, 32'h0, 1'b0, 4'hF, 1, 32'h5555_AAAA, 0, 1);
        chk("flush_cyc_len", 32'(cyc_total - base_c), 32'd2);
        chk("flush_bus_drop", 32'(bus.wb_cyc_o), 32'd0);

        base_c = cyc_total; base_e = err_total;
        do_access(32'h0000_0300, 32'h0, 1'b0, 4'hF, 99, 32'h0, 0, -1);
        idle_cycle();
        chk("timeout_cyc_len", 32'(cyc_total - base_c), 32'd4);
        chk("timeout_err_pulses", 32'(err_total - base_e), 32'd1);

        begin_cycle(); bus_idle();
        cpu_ce_i = 1; cpu_addr_i = 32'h400; cpu_data_i = 32'h0; cpu_we_i = 0; cpu_sel_i = 4'hF;
        stall_i = 1; flush_i = 0; bus.wb_ack_i = 0;
        exp_stallreq = 1; exp_cpu_data = '0;
        step();
        begin_cycle(); bus_act(32'h400, 32'h0, 1'b0, 4'hF);
        rst = 1;
        step();
        rst = 0;
        chk("reset_mid_cyc", 32'(bus.wb_cyc_o), 32'd0);
        base_e = err_total;
        idle_cycle();
        chk("reset_mid_err", 32'(err_total - base_e), 32'd0);

        for (int t = 0; t < 200; t++) begin
            waits = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 3));
            extra = int'($urandom_range(0, 3));
            fat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, (waits < 3) ? waits : 3)) : -1;
            do_access($urandom, $urandom, 1'($urandom), 4'($urandom), waits, $urandom, extra, fat);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        idle_cycle();

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
